// File: rtl/regfile_wport_ctrl.sv
// RegFile write-port owner: post-reset clear sweep of x1..x(REG_COUNT-1), then
// WB-priority sharing with a valid/ready debug requester plus a starvation guard.

module regfile_wport_ctrl #(
    parameter int REG_IDX_WIDTH = 5,
    parameter int WORD_LEN      = 32,
    parameter int REG_COUNT     = 32,
    parameter int MAX_WAIT      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_we,
    input  logic [REG_IDX_WIDTH-1:0] wb_waddr,
    input  logic [WORD_LEN-1:0]      wb_wdata,
    output logic                     wb_stall,
    input  logic                     dbg_valid,
    output logic                     dbg_ready,
    input  logic [REG_IDX_WIDTH-1:0] dbg_waddr,
    input  logic [WORD_LEN-1:0]      dbg_wdata,
    output logic                     rf_we,
    output logic [REG_IDX_WIDTH-1:0] rf_waddr,
    output logic [WORD_LEN-1:0]      rf_wdata,
    output logic                     init_done
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [REG_IDX_WIDTH-1:0] IDX_ZERO  = {REG_IDX_WIDTH{1'b0}};
    localparam logic [REG_IDX_WIDTH-1:0] IDX_ONE   = REG_IDX_WIDTH'(1);
    localparam logic [REG_IDX_WIDTH-1:0] LAST_IDX  = REG_IDX_WIDTH'(REG_COUNT - 1);
    localparam logic [WORD_LEN-1:0]      WORD_ZERO = {WORD_LEN{1'b0}};
    localparam logic [WAIT_W-1:0]        WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0]        WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0]        WAIT_MAX  = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [REG_IDX_WIDTH-1:0] clr_cnt_r;
    logic [REG_IDX_WIDTH-1:0] clr_cnt_nxt_s;
    logic [WAIT_W-1:0]        wait_cnt_r;
    logic [WAIT_W-1:0]        wait_cnt_nxt_s;
    logic                     init_done_r;
    logic                     init_done_nxt_s;
    logic                     wb_req_s;
    logic                     rf_we_s;
    logic [REG_IDX_WIDTH-1:0] rf_waddr_s;
    logic [WORD_LEN-1:0]      rf_wdata_s;
    logic                     dbg_ready_s;
    logic                     wb_stall_s;

    // A WB write aimed at x0 is treated as no request at all
    assign wb_req_s = wb_we && (wb_waddr != IDX_ZERO);

    // Port mux: sweep, WB-priority run, or the one-cycle forced debug slot
    always_comb begin
        rf_we_s     = 1'b0;
        rf_waddr_s  = IDX_ZERO;
        rf_wdata_s  = WORD_ZERO;
        dbg_ready_s = 1'b0;
        wb_stall_s  = 1'b1;
        case (state_r)
            ST_CLEAR: begin
                rf_we_s    = 1'b1;
                rf_waddr_s = clr_cnt_r;
                rf_wdata_s = WORD_ZERO;
                wb_stall_s = 1'b1;
            end
            ST_RUN: begin
                wb_stall_s = 1'b0;
                if (wb_req_s) begin
                    rf_we_s    = 1'b1;
                    rf_waddr_s = wb_waddr;
                    rf_wdata_s = wb_wdata;
                end else if (dbg_valid) begin
                    dbg_ready_s = 1'b1;
                    rf_we_s     = (dbg_waddr != IDX_ZERO);
                    rf_waddr_s  = dbg_waddr;
                    rf_wdata_s  = dbg_wdata;
                end else begin
                    rf_we_s = 1'b0;
                end
            end
            ST_FORCE: begin
                wb_stall_s  = 1'b1;
                dbg_ready_s = dbg_valid;
                rf_we_s     = dbg_valid && (dbg_waddr != IDX_ZERO);
                rf_waddr_s  = dbg_waddr;
                rf_wdata_s  = dbg_wdata;
            end
            default: begin
                rf_we_s    = 1'b0;
                wb_stall_s = 1'b1;
            end
        endcase
    end

    // Debug wait counter; saturates so a long wait during the sweep cannot wrap
    always_comb begin
        wait_cnt_nxt_s = WAIT_ZERO;
        if (state_r == ST_FORCE) begin
            wait_cnt_nxt_s = WAIT_ZERO;
        end else if (dbg_valid && !dbg_ready_s) begin
            if (wait_cnt_r == WAIT_MAX) begin
                wait_cnt_nxt_s = wait_cnt_r;
            end else begin
                wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
            end
        end else begin
            wait_cnt_nxt_s = WAIT_ZERO;
        end
    end

    // Next-state logic; FORCE is entered as the wait count reaches MAX_WAIT
    always_comb begin
        state_nxt_s     = state_r;
        clr_cnt_nxt_s   = clr_cnt_r;
        init_done_nxt_s = init_done_r;
        case (state_r)
            ST_CLEAR: begin
                clr_cnt_nxt_s = clr_cnt_r + IDX_ONE;
                if (clr_cnt_r == LAST_IDX) begin
                    state_nxt_s     = ST_RUN;
                    init_done_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (wait_cnt_nxt_s == WAIT_MAX) begin
                    state_nxt_s = ST_FORCE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FORCE: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_CLEAR;
            end
        endcase
    end

    // State registers with synchronous reset restarting the sweep at x1
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_CLEAR;
            clr_cnt_r   <= IDX_ONE;
            wait_cnt_r  <= WAIT_ZERO;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            clr_cnt_r   <= clr_cnt_nxt_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            init_done_r <= init_done_nxt_s;
        end
    end

    // Reset must also silence the port within the reset cycle itself
    assign rf_we     = rf_we_s & ~rst;
    assign dbg_ready = dbg_ready_s & ~rst;
    assign wb_stall  = wb_stall_s | rst;
    assign rf_waddr  = rf_waddr_s;
    assign rf_wdata  = rf_wdata_s;
    assign init_done = init_done_r;

    regfile_wport_ctrl_chk #(
        .REG_IDX_WIDTH(REG_IDX_WIDTH)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .dbg_valid (dbg_valid),
        .dbg_ready (dbg_ready)
    );

endmodule

// Protocol properties of the write port, kept apart from the datapath.
module regfile_wport_ctrl_chk #(
    parameter int REG_IDX_WIDTH = 5
) (
    input logic                     clk,
    input logic                     rst,
    input logic                     rf_we,
    input logic [REG_IDX_WIDTH-1:0] rf_waddr,
    input logic                     dbg_valid,
    input logic                     dbg_ready
);

    // x0 is hardwired; a write strobe must never target it
    a_no_x0_write: assert property (@(posedge clk) disable iff (rst)
        !(rf_we && (rf_waddr == {REG_IDX_WIDTH{1'b0}})));

    // Ready is only ever offered to a live request
    a_ready_needs_valid: assert property (@(posedge clk) disable iff (rst)
        !(dbg_ready && !dbg_valid));

endmodule

// File: tb/tb_regfile_wport_ctrl.sv
// Directed bench for regfile_wport_ctrl: sweep, WB/DBG arbitration, x0 rules,
// starvation guard and mid-operation reset, with hand-computed expectations.

module tb_regfile_wport_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_stall;
    logic        dbg_valid;
    logic        dbg_ready;
    logic [4:0]  dbg_waddr;
    logic [31:0] dbg_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        init_done;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_wport_ctrl #(
        .REG_IDX_WIDTH (5),
        .WORD_LEN      (32),
        .REG_COUNT     (32),
        .MAX_WAIT      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .wb_stall  (wb_stall),
        .dbg_valid (dbg_valid),
        .dbg_ready (dbg_ready),
        .dbg_waddr (dbg_waddr),
        .dbg_wdata (dbg_wdata),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .init_done (init_done)
    );

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic dv, input logic [4:0] da, input logic [31:0] dd);
        wb_we     = we;
        wb_waddr  = wa;
        wb_wdata  = wd;
        dbg_valid = dv;
        dbg_waddr = da;
        dbg_wdata = dd;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rf_we"},     {31'd0, rf_we},     32'd0);
        check({tag, "_dbg_ready"}, {31'd0, dbg_ready}, 32'd0);
        check({tag, "_wb_stall"},  {31'd0, wb_stall},  32'd1);
    endtask

    // Full sweep following a reset cycle; WB is asserted to show it is ignored
    task automatic sweep_check(input string tag);
        for (int i = 1; i <= 31; i++) begin
            next_cycle();
            rst = 1'b0;
            drive(1'b1, 5'd5, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0);
            #2;
            check({tag, "_we"},        {31'd0, rf_we},     32'd1);
            check({tag, "_addr"},      {27'd0, rf_waddr},  32'(i));
            check({tag, "_data"},      rf_wdata,           32'd0);
            check({tag, "_stall"},     {31'd0, wb_stall},  32'd1);
            check({tag, "_dbg_ready"}, {31'd0, dbg_ready}, 32'd0);
            check({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
        end
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        check({tag, "_init_done_set"}, {31'd0, init_done}, 32'd1);
        check({tag, "_stall_released"}, {31'd0, wb_stall}, 32'd0);
        check({tag, "_idle_we"},       {31'd0, rf_we},     32'd0);
    endtask

    // Directed sequence
    initial begin
        rst = 1'b1;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd7, 32'h1);

        next_cycle();
        #2;
        check_reset_outputs("reset");
        check("reset_init_done", {31'd0, init_done}, 32'd0);

        sweep_check("sweep");

        // WB write
        next_cycle();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        #2;
        check("wb_we",        {31'd0, rf_we},     32'd1);
        check("wb_addr",      {27'd0, rf_waddr},  32'd5);
        check("wb_data",      rf_wdata,           32'hDEADBEEF);
        check("wb_dbg_ready", {31'd0, dbg_ready}, 32'd0);
        check("wb_stall",     {31'd0, wb_stall},  32'd0);

        // Debug-only write
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);
        #2;
        check("dbg_ready", {31'd0, dbg_ready}, 32'd1);
        check("dbg_we",    {31'd0, rf_we},     32'd1);
        check("dbg_addr",  {27'd0, rf_waddr},  32'd7);
        check("dbg_data",  rf_wdata,           32'h12345678);

        // Starvation: grant lands on wait cycle 9, WB resumes on cycle 10
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            drive(1'b1, 5'd3, 32'h33333333, (c <= 9), 5'd9, 32'h99999999);
            #2;
            if (c <= 8) begin
                check("starve_wait_ready", {31'd0, dbg_ready}, 32'd0);
                check("starve_wait_addr",  {27'd0, rf_waddr},  32'd3);
                check("starve_wait_stall", {31'd0, wb_stall},  32'd0);
            end else if (c == 9) begin
                check("starve_force_stall", {31'd0, wb_stall},  32'd1);
                check("starve_force_ready", {31'd0, dbg_ready}, 32'd1);
                check("starve_force_we",    {31'd0, rf_we},     32'd1);
                check("starve_force_addr",  {27'd0, rf_waddr},  32'd9);
                check("starve_force_data",  rf_wdata,           32'h99999999);
            end else begin
                check("starve_after_addr",  {27'd0, rf_waddr},  32'd3);
                check("starve_after_data",  rf_wdata,           32'h33333333);
                check("starve_after_stall", {31'd0, wb_stall},  32'd0);
            end
        end

        // WB to x0 is no request, so the debug write goes through
        next_cycle();
        drive(1'b1, 5'd0, 32'hAAAAAAAA, 1'b1, 5'd4, 32'h44444444);
        #2;
        check("x0wb_dbg_ready", {31'd0, dbg_ready}, 32'd1);
        check("x0wb_we",        {31'd0, rf_we},     32'd1);
        check("x0wb_addr",      {27'd0, rf_waddr},  32'd4);
        check("x0wb_data",      rf_wdata,           32'h44444444);

        // Debug write to x0 is accepted and dropped
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55555555);
        #2;
        check("x0dbg_ready", {31'd0, dbg_ready}, 32'd1);
        check("x0dbg_we",    {31'd0, rf_we},     32'd0);

        // Requester drops valid on the forced cycle: slot still taken, nothing written
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            drive(1'b1, 5'd3, 32'h77777777, (c <= 8), 5'd9, 32'h99999999);
            #2;
            if (c == 9) begin
                check("drop_force_stall", {31'd0, wb_stall},  32'd1);
                check("drop_force_we",    {31'd0, rf_we},     32'd0);
                check("drop_force_ready", {31'd0, dbg_ready}, 32'd0);
            end else if (c == 10) begin
                check("drop_after_we",    {31'd0, rf_we},     32'd1);
                check("drop_after_addr",  {27'd0, rf_waddr},  32'd3);
                check("drop_after_stall", {31'd0, wb_stall},  32'd0);
            end else begin
                check("drop_wait_ready", {31'd0, dbg_ready}, 32'd0);
            end
        end

        // Reset landing on the forced cycle
        for (int c = 1; c <= 9; c++) begin
            next_cycle();
            drive(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd9, 32'h99999999);
            if (c == 9) begin
                rst = 1'b1;
            end
            #2;
            if (c == 9) begin
                check_reset_outputs("rst_force");
            end else begin
                check("rst_force_wait_ready", {31'd0, dbg_ready}, 32'd0);
            end
        end
        sweep_check("resweep");

        // Reset in the middle of a debug wait in RUN
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            drive(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd9, 32'h99999999);
            if (c == 4) begin
                rst = 1'b1;
            end
            #2;
            if (c == 4) begin
                check_reset_outputs("rst_wait");
            end else begin
                check("rst_wait_ready", {31'd0, dbg_ready}, 32'd0);
            end
        end
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        check("rst_wait_restart_addr", {27'd0, rf_waddr},  32'd1);
        check("rst_wait_restart_we",   {31'd0, rf_we},     32'd1);
        check("rst_wait_init_done",    {31'd0, init_done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
